// File: rtl/input_control_pkg.sv
// Shared definitions for the pushbutton input path: debounce FSM encoding
// and the default debounce window.
package input_control_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the raw asynchronous button level into clk.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/input_debounce.sv
// Pushbutton debouncer: synchronizes the raw level, accepts a change only after
// DEBOUNCE_CYCLES stable samples, and emits press/release strobes and a press count.
module input_debounce
    import input_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count,
    output state_t     state_dbg
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             press_next, release_next;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so the level and the
    // strobe appear together in the cycle after the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            btn_level     <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
            press_pulse   <= press_next;
            release_pulse <= release_next;
            if (press_next) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    assign state_dbg = state;

endmodule
